// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: synchroniser, shared sample timer, two-way debounce,
// press/release strobes and optional auto-repeat (strobe ports carry a suffix because release/repeat are keywords).
module button_conditioner #(
    parameter int               WIDTH            = 4,
    parameter int               SYNC_STAGES      = 2,
    parameter int               SAMPLE_COUNT_MAX = 45000,
    parameter int               PULSE_COUNT_MAX  = 200,
    parameter logic [WIDTH-1:0] REPEAT_MASK      = '0,
    parameter int               REPEAT_DELAY     = 1000,
    parameter int               REPEAT_PERIOD    = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_strobe,
    output logic [WIDTH-1:0] repeat_strobe
);

    localparam int SW = (SAMPLE_COUNT_MAX > 1) ? $clog2(SAMPLE_COUNT_MAX) : 1;
    localparam int PW = (PULSE_COUNT_MAX > 1) ? $clog2(PULSE_COUNT_MAX) : 1;
    localparam int RW = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;

    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_COUNT_MAX - 1);
    localparam logic [PW-1:0] DB_LAST     = PW'(PULSE_COUNT_MAX - 1);
    localparam logic [RW-1:0] RC_LAST     = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RC_RELOAD   = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    generate
        if (WIDTH < 1 || SYNC_STAGES < 2 || SAMPLE_COUNT_MAX < 1 || PULSE_COUNT_MAX < 1 ||
            REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
            $error("button_conditioner: illegal parameter combination");
        end
    endgenerate

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [SW-1:0]    sample_cnt;
    logic             tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign tick = (sample_cnt == SAMPLE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       sample_cnt <= '0;
        else if (tick) sample_cnt <= '0;
        else           sample_cnt <= sample_cnt + SW'(1);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [PW-1:0] db_q;
        logic          level_q;
        logic          level_n;
        logic          press_q;
        logic          release_q;

        // Level flips only on the tick that completes a full run of disagreeing samples.
        always_comb begin
            level_n = level_q;
            if (tick && (s[i] != level_q) && (db_q == DB_LAST)) level_n = s[i];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                db_q      <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                if (tick) begin
                    if ((s[i] == level_q) || (db_q == DB_LAST)) db_q <= '0;
                    else                                        db_q <= db_q + PW'(1);
                end
                level_q   <= level_n;
                press_q   <= level_n & ~level_q;
                release_q <= ~level_n & level_q;
            end
        end

        assign level[i]          = level_q;
        assign press[i]          = press_q;
        assign release_strobe[i] = release_q;

        if (REPEAT_MASK[i]) begin : g_rep
            logic [RW-1:0] rc_q;
            logic          rep_q;

            // Suppressed on the tick that drops level so no strobe lands in the release cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rc_q  <= '0;
                    rep_q <= 1'b0;
                end else begin
                    rep_q <= tick && level_q && level_n && !press_q && (rc_q == RC_LAST);
                    if (!level_q || press_q) rc_q <= '0;
                    else if (tick)           rc_q <= (rc_q == RC_LAST) ? RC_RELOAD : rc_q + RW'(1);
                end
            end

            assign repeat_strobe[i] = rep_q;
        end else begin : g_no_rep
            assign repeat_strobe[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: per-cycle scoreboard against a behavioural model,
// a table of hold/release segments with pulse counts, and hand-written reset sequences.
module tb_button_conditioner;

    localparam int         W     = 4;
    localparam int         SS    = 2;
    localparam int         SCM   = 4;
    localparam int         PCM   = 3;
    localparam int         RD    = 5;
    localparam int         RP    = 2;
    localparam logic [3:0] RMASK = 4'b0001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in  = 4'h0;
    logic [3:0] level, press, release_strobe, repeat_strobe;

    button_conditioner #(
        .WIDTH(W), .SYNC_STAGES(SS), .SAMPLE_COUNT_MAX(SCM), .PULSE_COUNT_MAX(PCM),
        .REPEAT_MASK(RMASK), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .in(in), .level(level), .press(press),
        .release_strobe(release_strobe), .repeat_strobe(repeat_strobe)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] rep;
    } obs_t;

    typedef struct {
        logic [3:0]  in_v;
        int          cycles;
        logic [3:0]  lvl;
        logic [15:0] np;
        logic [15:0] nr;
        logic [15:0] nt;
    } vec_t;

    obs_t exp_q[$];
    vec_t vec[8];
    int   n_cmp = 0;
    int   n_bad = 0;

    // behavioural reference state
    logic [3:0] m_sync1, m_sync2, m_level, m_press, m_rel, m_rep;
    logic [3:0] rmask;
    int         m_phase;
    int         m_db[4];
    int         m_held[4];

    int         step_no;
    int         cnt_p[4], cnt_r[4], cnt_t[4], first_press[4];
    logic [3:0] rv;
    int         k;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_edge(input logic [3:0] v, input logic r);
        logic       tick;
        logic [3:0] nxt, rep_n;
        if (r) begin
            m_sync1 = '0; m_sync2 = '0; m_level = '0;
            m_press = '0; m_rel = '0; m_rep = '0; m_phase = 0;
            for (int ch = 0; ch < 4; ch++) begin m_db[ch] = 0; m_held[ch] = 0; end
            return;
        end
        tick = ((m_phase % SCM) == SCM - 1);
        m_phase++;
        nxt   = m_level;
        rep_n = '0;
        for (int ch = 0; ch < 4; ch++) begin
            if (tick) begin
                if (m_sync2[ch] != m_level[ch]) begin
                    m_db[ch]++;
                    if (m_db[ch] == PCM) begin nxt[ch] = m_sync2[ch]; m_db[ch] = 0; end
                end else begin
                    m_db[ch] = 0;
                end
            end
            if (!m_level[ch] || m_press[ch]) begin
                m_held[ch] = 0;
            end else if (tick) begin
                m_held[ch]++;
                if (rmask[ch] && nxt[ch] &&
                    (m_held[ch] == RD || (m_held[ch] > RD && ((m_held[ch] - RD) % RP) == 0)))
                    rep_n[ch] = 1'b1;
            end
        end
        m_press = nxt & ~m_level;
        m_rel   = ~nxt & m_level;
        m_rep   = rep_n;
        m_level = nxt;
        m_sync2 = m_sync1;
        m_sync1 = v;
    endtask

    task automatic clear_counts();
        step_no = 0;
        for (int ch = 0; ch < 4; ch++) begin
            cnt_p[ch] = 0; cnt_r[ch] = 0; cnt_t[ch] = 0; first_press[ch] = -1;
        end
    endtask

    task automatic step(input logic [3:0] v, input logic r);
        obs_t e, a;
        in  = v;
        rst = r;
        @(posedge clk);
        model_edge(v, r);
        exp_q.push_back({m_level, m_press, m_rel, m_rep});
        @(negedge clk);
        step_no++;
        a = {level, press, release_strobe, repeat_strobe};
        e = exp_q.pop_front();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL scoreboard step %0d: level/press/release/repeat got %b_%b_%b_%b expected %b_%b_%b_%b",
                     step_no, a.lvl, a.prs, a.rel, a.rep, e.lvl, e.prs, e.rel, e.rep);
        end
        for (int ch = 0; ch < 4; ch++) begin
            if (press[ch]) begin
                cnt_p[ch]++;
                if (first_press[ch] < 0) first_press[ch] = step_no;
            end
            if (release_strobe[ch]) cnt_r[ch]++;
            if (repeat_strobe[ch])  cnt_t[ch]++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rmask = RMASK;
        model_edge(4'h0, 1'b1);
        clear_counts();

        // in, cycles, final level, press/release/repeat counts (one nibble per channel, ch3 leftmost)
        vec[0] = '{4'b0001,  6, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
        vec[1] = '{4'b0000, 20, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
        vec[2] = '{4'b0010, 20, 4'b0010, 16'h0010, 16'h0000, 16'h0000};
        vec[3] = '{4'b0000, 20, 4'b0000, 16'h0000, 16'h0010, 16'h0000};
        vec[4] = '{4'b0101, 60, 4'b0101, 16'h0101, 16'h0000, 16'h0004};
        vec[5] = '{4'b0000, 20, 4'b0000, 16'h0000, 16'h0101, 16'h0001};
        vec[6] = '{4'b1001, 20, 4'b1001, 16'h1001, 16'h0000, 16'h0000};
        vec[7] = '{4'b0000, 20, 4'b0000, 16'h0000, 16'h1001, 16'h0000};

        // buttons held through reset
        for (int i = 0; i < 3; i++) begin
            step(4'hF, 1'b1);
            check("reset_outputs_quiet", int'({level, press, release_strobe, repeat_strobe}), 0);
        end
        clear_counts();
        for (int i = 0; i < 20; i++) step(4'hF, 1'b0);
        for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("post_reset_press_count[%0d]", ch), cnt_p[ch], 1);
            check($sformatf("post_reset_press_step[%0d]", ch), first_press[ch], 12);
        end
        clear_counts();
        for (int i = 0; i < 20; i++) step(4'h0, 1'b0);
        check("post_reset_release_level", int'(level), 0);
        for (int ch = 0; ch < 4; ch++)
            check($sformatf("post_reset_release_count[%0d]", ch), cnt_r[ch], 1);

        foreach (vec[j]) begin
            clear_counts();
            for (int i = 0; i < vec[j].cycles; i++) step(vec[j].in_v, 1'b0);
            check($sformatf("vec%0d_level", j), int'(level), int'(vec[j].lvl));
            for (int ch = 0; ch < 4; ch++) begin
                check($sformatf("vec%0d_press[%0d]", j, ch),   cnt_p[ch], int'(vec[j].np[ch*4 +: 4]));
                check($sformatf("vec%0d_release[%0d]", j, ch), cnt_r[ch], int'(vec[j].nr[ch*4 +: 4]));
                check($sformatf("vec%0d_repeat[%0d]", j, ch),  cnt_t[ch], int'(vec[j].nt[ch*4 +: 4]));
            end
            if (vec[j].in_v == 4'b1001)
                check("simultaneous_press_step_ch0_vs_ch3", first_press[0], first_press[3]);
        end

        // reset while channel 1 sits two disagreeing samples into its debounce
        clear_counts();
        k = 0;
        while (m_db[1] != 2 && k < 30) begin
            step(4'b0010, 1'b0);
            k++;
        end
        check("mid_debounce_reached", int'(k < 30), 1);
        check("mid_debounce_level_before_reset", int'(level[1]), 0);
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b1);
        check("mid_debounce_level_in_reset", int'(level), 0);
        clear_counts();
        for (int i = 0; i < 20; i++) step(4'b0010, 1'b0);
        check("mid_debounce_press_count", cnt_p[1], 1);
        check("mid_debounce_press_step", first_press[1], 12);
        for (int i = 0; i < 20; i++) step(4'b0000, 1'b0);

        // random bounce with occasional reset, scored cycle by cycle
        rv = 4'h0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) rv[$urandom_range(0, 3)] = ~rv[$urandom_range(0, 3)];
            step(rv, ($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
